// File: rtl/aes_decrypt_core_if.sv
// Purpose: request/result bundle for the AES-128 decrypt core.
// Latency: none (wires only).
// Backpressure: none; enb is a start strobe that is honoured only while the core is idle.
// Signals:
//   enb           - start request (master -> core)
//   key           - AES-128 cipher key (master -> core)
//   ciphertext    - block to decrypt, byte 0 in bits [127:120] (master -> core)
//   plaintext_out - registered decrypted block (core -> master)
//   busy          - core is working on a block (core -> master)
//   done          - one-cycle pulse when plaintext_out updates (core -> master)
interface aes_decrypt_core_if #(
    parameter int n = 128
) ();
    logic         enb;
    logic [n-1:0] key;
    logic [n-1:0] ciphertext;
    logic [n-1:0] plaintext_out;
    logic         busy;
    logic         done;

    modport master (
        output enb,
        output key,
        output ciphertext,
        input  plaintext_out,
        input  busy,
        input  done
    );

    modport slave (
        input  enb,
        input  key,
        input  ciphertext,
        output plaintext_out,
        output busy,
        output done
    );
endinterface

// File: rtl/aes_decrypt_core.sv
// Purpose: iterative FIPS-197 AES-128 inverse cipher, one round per clock.
// Latency: 21 edges accept->done (11 on a key-cache hit when AES_DEC_KEY_CACHE_EN is defined).
// Backpressure: none; enb is ignored while busy, nothing is queued.
// Ports: clk (rising edge), rst (synchronous, active low), io (aes_decrypt_core_if.slave:
//   enb/key/ciphertext in, plaintext_out/busy/done out).
// Optional build macro AES_DEC_KEY_CACHE_EN: keep the expanded round keys of the last key and
//   skip key expansion when the next block arrives with the same key.
// Also holds the shared S-box modules (aes_gf_inv, aes_sbox, aes_inv_sbox), computed
//   arithmetically rather than from lookup tables.

// Multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, as a^254 (0 maps to 0).
module aes_gf_inv (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    // Square-and-multiply: product of a^2, a^4 ... a^128 = a^254.
    always_comb begin
        logic [7:0] s;
        logic [7:0] r;
        s = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        y = r;
    end
endmodule

// Forward S-box: inverse followed by the affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] b;

    aes_gf_inv u_inv (.a(a), .y(b));

    assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine map followed by the field inverse.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] b;

    assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

    aes_gf_inv u_inv (.a(b), .y(y));
endmodule

module aes_decrypt_core #(
    parameter int n = 128
) (
    input  logic              clk,
    input  logic              rst,
    aes_decrypt_core_if.slave io
);
    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   cnt;
    logic [n-1:0] ct_q;
    logic [n-1:0] st_q;
    // rk[0] is the captured cipher key; rk[1..10] are filled during KEXP.
    logic [n-1:0] rk [0:10];

    logic         cache_hit;
    logic         cap_en;
    logic         rk_we;
    logic         st_init;
    logic         st_round;
    logic         st_final;

`ifdef AES_DEC_KEY_CACHE_EN
    logic cache_vld;
    // rk[0] doubles as the cached key: it only differs from the expanded file while
    // cache_vld is low (between a miss and the end of its KEXP).
    assign cache_hit = cache_vld && (io.key == rk[0]);
`else
    assign cache_hit = 1'b0;
`endif

    // ---------------- key expansion step: rk[cnt] from rk[cnt-1] ----------------
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [n-1:0] rk_prev;
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [31:0]  tmp_w;
    logic [31:0]  w0, w1, w2, w3;
    logic [n-1:0] rk_nxt;

    assign rk_prev = rk[cnt - 4'd1];
    assign rot_w   = {rk_prev[23:0], rk_prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_ksbox
        aes_sbox u_sbox (.a(rot_w[8*g +: 8]), .y(sub_w[8*g +: 8]));
    end

    assign tmp_w  = sub_w ^ {rcon(cnt), 24'h000000};
    assign w0     = rk_prev[127:96] ^ tmp_w;
    assign w1     = rk_prev[95:64]  ^ w0;
    assign w2     = rk_prev[63:32]  ^ w1;
    assign w3     = rk_prev[31:0]   ^ w2;
    assign rk_nxt = {w0, w1, w2, w3};

    // ---------------- round datapath ----------------
    // Byte k of the block lives at bits [127-8k -: 8]; k = 4*column + row.
    function automatic logic [n-1:0] inv_shift_rows(input logic [n-1:0] s);
        logic [n-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [n-1:0] inv_mix_columns(input logic [n-1:0] s);
        logic [n-1:0] o;
        logic [7:0]   a [4];
        logic [7:0]   x2, x4, x8;
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127 - 8*(4*c + r) -: 8];
                x2    = xt(a[r]);
                x4    = xt(x2);
                x8    = xt(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127 - 8*(4*c + 0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[127 - 8*(4*c + 1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[127 - 8*(4*c + 2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[127 - 8*(4*c + 3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    logic [n-1:0] isr;
    logic [n-1:0] isb;
    logic [n-1:0] ark;

    assign isr = inv_shift_rows(st_q);

    for (genvar g = 0; g < 16; g++) begin : g_isbox
        aes_inv_sbox u_isbox (.a(isr[8*g +: 8]), .y(isb[8*g +: 8]));
    end

    // cnt is 9..1 in ROUND and 0 in FINAL, so rk[cnt] also yields rk0 for the last step.
    assign ark = isb ^ rk[cnt];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.enb) state_nxt = cache_hit ? INIT : KEXP;
            KEXP:    if (cnt == 4'd10) state_nxt = INIT;
            INIT:    state_nxt = ROUND;
            ROUND:   if (cnt == 4'd1) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cap_en   = 1'b0;
        rk_we    = 1'b0;
        st_init  = 1'b0;
        st_round = 1'b0;
        st_final = 1'b0;
        case (state)
            IDLE:    cap_en   = io.enb;
            KEXP:    rk_we    = 1'b1;
            INIT:    st_init  = 1'b1;
            ROUND:   st_round = 1'b1;
            FINAL:   st_final = 1'b1;
            default: ;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt              <= 4'd0;
            io.busy          <= 1'b0;
            io.done          <= 1'b0;
            io.plaintext_out <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_vld        <= 1'b0;
`endif
        end else begin
            io.done <= 1'b0;
            if (cap_en) begin
                rk[0]   <= io.key;
                ct_q    <= io.ciphertext;
                io.busy <= 1'b1;
                cnt     <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
                // A miss invalidates the file until its expansion completes.
                cache_vld <= cache_hit;
`endif
            end
            if (rk_we) begin
                rk[cnt] <= rk_nxt;
                cnt     <= cnt + 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
                if (cnt == 4'd10) cache_vld <= 1'b1;
`endif
            end
            if (st_init) begin
                st_q <= ct_q ^ rk[10];
                cnt  <= 4'd9;
            end
            if (st_round) begin
                st_q <= inv_mix_columns(ark);
                cnt  <= cnt - 4'd1;
            end
            if (st_final) begin
                io.plaintext_out <= ark;
                io.done          <= 1'b1;
                io.busy          <= 1'b0;
            end
        end
    end
endmodule

// File: doc/aes_decrypt_core.md
AES_DECRYPT_CORE -- requirements
Module: aes_decrypt_core

Interface
REQ-001 Parameter n, default 128, block and key width; the only supported value SHALL be 128.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 enb  input  1  start request; sampled only while idle.
REQ-005 key  input  n  AES-128 cipher key (the same key used by the encryptor).
REQ-006 ciphertext  input  n  block to decrypt, byte 0 in bits [127:120].
REQ-007 plaintext_out  output  n  decrypted block, registered.
REQ-008 busy  output  1  high from the accepting edge until the done edge.
REQ-009 done  output  1  one-cycle pulse when plaintext_out is updated.

Function
REQ-010 The block SHALL implement the FIPS-197 AES-128 inverse cipher iteratively, with one round per cycle.
REQ-011 The block SHALL instantiate the codebase's shared forward S-box (key schedule) and inverse S-box (state) modules and SHALL NOT use local S-box tables.
REQ-012 FSM states SHALL be IDLE, KEXP, INIT, ROUND, FINAL.
REQ-013 IDLE: on an edge with enb=1, the block SHALL capture key and ciphertext, set busy=1, and go to KEXP.
REQ-014 KEXP: the block SHALL take 10 cycles, produce rk1..rk10 (one per cycle, using Rcon 01..36), store them in the round-key file, then go to INIT.
REQ-015 INIT: the block SHALL set state = ciphertext XOR rk10 in one cycle, set the round counter to 9, and go to ROUND.
REQ-016 ROUND: each cycle SHALL apply InvShiftRows, InvSubBytes, XOR rk[counter], InvMixColumns; the counter SHALL decrement, and the block SHALL exit to FINAL after round 1 (9 cycles).
REQ-017 FINAL: the block SHALL apply InvShiftRows, InvSubBytes, XOR rk0 (the captured key), load plaintext_out, pulse done=1 and set busy=0 on the same edge, then return to IDLE.
REQ-018 Latency SHALL be 21 edges from the accepting edge to the done edge, without a cache hit.
REQ-019 enb SHALL be ignored while busy=1; no queuing.
REQ-020 Changes on key and ciphertext after the accepting edge SHALL have no effect on the block in progress.
REQ-021 plaintext_out SHALL hold its value until the next done edge.
REQ-022 enb high on the edge that returns the FSM to IDLE SHALL NOT be accepted; acceptance requires the FSM to already be in IDLE.
REQ-023 All GF(2^8) arithmetic SHALL be mod x^8+x^4+x^3+x+1; InvMixColumns SHALL use coefficients 0e,0b,0d,09.

Reset
REQ-024 rst=0 at a clock edge SHALL force IDLE, with plaintext_out=0, busy=0, done=0, the round counter at 0, and the key-cache valid flag cleared.
REQ-025 Reset asserted mid-operation SHALL abort the block, with no done pulse; an enb on the first edge after release SHALL be accepted normally.

Configuration
REQ-026 Macro AES_DEC_KEY_CACHE_EN, when defined: the block SHALL keep the round-key file and last key with a valid flag; on acceptance with a key equal to the cached key and valid=1, IDLE SHALL go directly to INIT, giving a latency of 11 edges.
REQ-027 On a key mismatch with the macro defined, the block SHALL perform KEXP (latency 21) and set valid=1 afterwards.
REQ-028 Without the macro: no cache registers and no comparator SHALL exist; KEXP SHALL always run and latency SHALL always be 21.

Verification
REQ-029 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext_out 00112233445566778899aabbccddeeff, done exactly 21 edges after acceptance, busy high throughout.
REQ-030 All-zero key, ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e -> plaintext_out all zeros; loopback through the encrypting top with key 128'd80985098094558981234567890 returns the original plaintext.
REQ-031 With AES_DEC_KEY_CACHE_EN defined: two back-to-back C.1 blocks with the same key -> second done at 11 edges; a changed key -> 21 edges.
REQ-032 enb held high for the whole operation, with ciphertext changed mid-operation -> exactly one done, result from the originally captured ciphertext, next acceptance only from IDLE.
REQ-033 rst=0 at edge 8 of an operation -> no done pulse, outputs zero; restart after release -> correct C.1 result at 21 edges, even with the cache macro enabled.
